// File: rtl/gray_dec_pkg.sv
// Shared definitions for the sequential Gray-to-binary decoder: FSM states,
// default width and the parity helper used by the optional parity output.
package gray_dec_pkg;

   localparam int GRAY_DEC_WIDTH_DEFAULT = 8;
   localparam int GRAY_DEC_WIDTH_MAX     = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } gray_dec_state_e;

   // Even-parity reduction; narrower words are zero-extended by the caller.
   function automatic logic gray_dec_parity(input logic [GRAY_DEC_WIDTH_MAX-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/gray_decoder_seq.sv
// Bit-serial Gray-to-binary decoder: one output bit per cycle, MSB first,
// with a valid/ready handshake on both sides. Optional GRAY_DEC_PARITY_EN adds out_parity.
module gray_decoder_seq
   import gray_dec_pkg::*;
#(
   parameter int WIDTH = GRAY_DEC_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
`ifdef GRAY_DEC_PARITY_EN
   output logic             out_parity,
`endif
   output logic             busy
);

   localparam int               IDX_W   = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 2);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

   gray_dec_state_e  state_r;
   gray_dec_state_e  state_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_s;
   logic [WIDTH-1:0] xreg_r;
   logic [WIDTH-1:0] xreg_s;
   logic [WIDTH-1:0] y_r;
   logic [WIDTH-1:0] y_s;
   logic [WIDTH-1:0] y_shift_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   // One decode step: bit idx takes the XOR of the bit above it and the captured Gray bit.
   always_comb begin
      y_shift_s = y_r;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == WIDTH - 1) begin
            // The MSB is never recomputed; it always mirrors the captured Gray MSB.
            y_shift_s[i] = xreg_r[i];
         end else if (idx_r == IDX_W'(i)) begin
            y_shift_s[i] = y_r[i+1] ^ xreg_r[i];
         end else begin
            y_shift_s[i] = y_r[i];
         end
      end
   end

   // Next-state, index and datapath selection for the IDLE/SHIFT/DONE controller.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      xreg_s  = xreg_r;
      y_s     = y_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               xreg_s  = x;
               y_s     = {x[WIDTH-1], {(WIDTH-1){1'b0}}};
               idx_s   = IDX_TOP;
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            y_s = y_shift_s;
            if (idx_r == IDX_ZERO) begin
               // Index saturates at zero; the controller leaves SHIFT instead of wrapping.
               idx_s   = IDX_ZERO;
               state_s = DONE;
            end else begin
               idx_s   = idx_r - IDX_ONE;
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
            idx_s   = IDX_ZERO;
         end
      endcase
   end

   // Controller state, captured word, index and decoded result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= IDX_ZERO;
         xreg_r  <= {WIDTH{1'b0}};
         y_r     <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         xreg_r  <= xreg_s;
         y_r     <= y_s;
      end
   end

   // Handshake and status flags, registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == DONE);
         busy_r      <= (state_s != IDLE);
      end
   end

`ifdef GRAY_DEC_PARITY_EN
   logic out_parity_r;

   // Parity of the finished word, captured on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_parity_r <= 1'b0;
      end else if ((state_r == SHIFT) && (state_s == DONE)) begin
         out_parity_r <= gray_dec_parity(GRAY_DEC_WIDTH_MAX'(y_shift_s));
      end else begin
         out_parity_r <= out_parity_r;
      end
   end

   assign out_parity = out_parity_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign y         = y_r;

endmodule

// File: tb/tb_gray_decoder_seq.sv
// Scoreboard bench for gray_decoder_seq: a cycle model predicts handshake flags,
// accepted words are queued with their expected decode and checked while in DONE.
module tb_gray_decoder_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         busy;
`ifdef GRAY_DEC_PARITY_EN
   logic         out_parity;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef enum int {M_IDLE, M_SHIFT, M_DONE} model_state_e;
   model_state_e m_state = M_IDLE;
   int           m_cnt   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_y  = '0;

   always #5 clk = ~clk;

   gray_decoder_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
`ifdef GRAY_DEC_PARITY_EN
      .out_parity(out_parity),
`endif
      .busy      (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference inverse as a prefix XOR of right shifts of the Gray word.
   function automatic logic [W-1:0] gray_inv(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   // Mid-cycle monitor: checks outputs against the model, then advances the model for the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            exp_q.delete();
            last_y  = '0;
`ifdef GRAY_DEC_PARITY_EN
            check_eq("rst_parity", 32'(out_parity), 32'd0);
`endif
         end
         check_eq("in_ready", 32'(in_ready), 32'(m_state == M_IDLE));
         check_eq("out_valid", 32'(out_valid), 32'(m_state == M_DONE));
         check_eq("busy", 32'(busy), 32'(m_state != M_IDLE));
         if (m_state == M_IDLE) begin
            check_eq("y_hold", 32'(y), 32'(last_y));
         end else if (m_state == M_DONE) begin
            if (exp_q.size() > 0) begin
               check_eq("y_out", 32'(y), 32'(gray_inv(exp_q[0])));
               check_eq("gray_roundtrip", 32'(y ^ (y >> 1)), 32'(exp_q[0]));
`ifdef GRAY_DEC_PARITY_EN
               check_eq("out_parity", 32'(out_parity), 32'(^gray_inv(exp_q[0])));
`endif
            end else begin
               check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end
         end
         if (rst_n) begin
            case (m_state)
               M_IDLE: if (in_valid) begin
                  exp_q.push_back(x);
                  m_state = M_SHIFT;
                  m_cnt   = W - 1;
               end
               M_SHIFT: begin
                  m_cnt--;
                  if (m_cnt == 0) m_state = M_DONE;
               end
               M_DONE: if (out_ready) begin
                  if (exp_q.size() > 0) last_y = gray_inv(exp_q.pop_front());
                  m_state = M_IDLE;
               end
               default: m_state = M_IDLE;
            endcase
         end
      end
   end

   // Drive one word and wait until it has been consumed; called just after a rising edge.
   task automatic send(input logic [W-1:0] w);
      bit got;
      in_valid = 1'b1;
      x        = w;
      got      = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
      end
      if (!got) check_eq("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #2 in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = out_valid && out_ready;
      end
      if (!got) check_eq("done_timeout", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      repeat (2) @(posedge clk);
      #2;
      check_eq("rst_y", 32'(y), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);

      // Release reset with a word already offered: it must be taken on the first edge.
      rst_n = 1'b1;
      send(8'b1010_1000);
      check_eq("y_a8", 32'(y), 32'hCF);
      send(8'hFF);
      check_eq("y_ff", 32'(y), 32'hAA);
      send(8'h80);
      check_eq("y_80", 32'(y), 32'hFF);
      send(8'h00);
      check_eq("y_00", 32'(y), 32'h00);
      send(8'h01);
      check_eq("y_01", 32'(y), 32'h01);

      // Back-pressure: hold out_ready low for 5 cycles in DONE.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x         = 8'h5A;
      @(posedge clk);
      #2 in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) @(posedge clk);
      #2;
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      repeat (5) @(posedge clk);
      #2;
      check_eq("bp_y_stable", 32'(y), 32'(gray_inv(8'h5A)));
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      check_eq("bp_release_valid", 32'(out_valid), 32'd0);
      check_eq("bp_release_ready", 32'(in_ready), 32'd1);

      // Continuous in_valid with a changing word: only idle-cycle words are decoded.
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         x = W'($urandom);
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;

      // Asynchronous reset during the third SHIFT cycle aborts the word.
      in_valid = 1'b1;
      x        = 8'h3C;
      @(posedge clk);
      #2 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("abort_y", 32'(y), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      send(8'hC3);
      check_eq("y_after_abort", 32'(y), 32'(gray_inv(8'hC3)));

      // Every Gray code of the default width.
      for (int g = 0; g < 256; g++) send(W'(g));

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_decoder_seq.md
GRAY_DECODER_SEQ -- requirements
Module: gray_decoder_seq

Interface
REQ-001 Parameter WIDTH, default 8: code word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  x holds a Gray-coded word to accept.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 x  input  WIDTH  Gray-coded input word.
REQ-007 out_valid  output  1  y holds a decoded binary word.
REQ-008 out_ready  input  1  consumer takes y this cycle.
REQ-009 y  output  WIDTH  decoded binary word.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL implement the FSM states IDLE, SHIFT and DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-012 Input accept: on an edge in IDLE with in_valid=1, the block SHALL register x, set y[WIDTH-1]=x[WIDTH-1], clear the other y bits, load bit index = WIDTH-2 and enter SHIFT.
REQ-013 SHIFT: each edge the block SHALL compute y[i] = y[i+1] XOR xreg[i] for the current index i, then decrement the index.
REQ-014 When i=0 is computed, the block SHALL enter DONE; y is valid.
REQ-015 Latency: out_valid SHALL rise exactly WIDTH-1 cycles after the accepting edge, which is 7 cycles at WIDTH=8.
REQ-016 DONE: the block SHALL hold y and out_valid stable until out_ready=1, then return to IDLE; out_valid SHALL be low from the next cycle.
REQ-017 y SHALL retain its last value in IDLE and SHALL change only at the next accept.
REQ-018 in_valid while busy SHALL be ignored, with no capture and no state change.
REQ-019 in_valid=1 on the same edge DONE is left SHALL NOT be accepted, because in_ready is 0 on that edge; the earliest accept is one cycle later.
REQ-020 out_ready outside DONE SHALL have no effect.
REQ-021 The index counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap below 0; the state exits at 0.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, y=0, xreg=0, index=0, out_valid=0, busy=0 and in_ready=1.
REQ-023 Reset during SHIFT or DONE SHALL abort the word with no output produced.
REQ-024 After rst_n deasserts, the first accept SHALL be possible on the first edge.

Configuration
REQ-025 Macro GRAY_DEC_PARITY_EN, when defined, SHALL add output out_parity (1 bit) = XOR of all bits of y.
REQ-026 out_parity SHALL be registered on the DONE-entry edge, valid while out_valid=1, and reset to 0.
REQ-027 Without GRAY_DEC_PARITY_EN, the out_parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package gray_dec_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and localparam GRAY_DEC_WIDTH_DEFAULT = 8.
REQ-029 No sub-module SHALL be used; the FSM, index counter and datapath stay in gray_decoder_seq.

Verification
REQ-030 Apply x=8'b10101000 with in_valid for 1 cycle and out_ready=1 -> out_valid rises 7 cycles after accept with y=8'hCF; out_parity=0 when the macro is defined.
REQ-031 Apply x=8'hFF -> y=8'hAA; x=8'h80 -> y=8'hFF; x=8'h00 -> y=8'h00; x=8'h01 -> y=8'h01.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> y and out_valid stay stable; the cycle after out_ready=1, out_valid=0 and in_ready=1.
REQ-033 Hold in_valid=1 continuously with a changing x -> only the words present on cycles with in_ready=1 are decoded, and accepts are spaced >= 9 cycles with out_ready=1.
REQ-034 Pulse rst_n=0 at the 3rd SHIFT cycle -> y=0, in_ready=1 and out_valid=0 asynchronously; the next word decodes correctly.
REQ-035 Exhaustive check at WIDTH=8: all 256 Gray codes -> y equals the reference inverse, where gray(y) == x.
